// File: rtl/force_reduce_pkg.sv
// Shared state encoding, FIFO entry field offsets and sign-extension helper
// for the force reduction drain stage.
package force_reduce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_EMIT
  } state_e;

  // Widest operand the sign-extension helper handles.
  localparam int unsigned SEXT_MAX = 64;

  // FIFO word layout: {last, id, value} with value in the low bits.
  function automatic int id_lsb(input int val_w);
    return val_w;
  endfunction

  function automatic int last_bit(input int id_w, input int val_w);
    return id_w + val_w;
  endfunction

  // Replicates bit w-1 of v into every bit above it.
  function automatic logic [SEXT_MAX-1:0] sext(input logic [SEXT_MAX-1:0] v, input int w);
    return $signed(v << (SEXT_MAX - w)) >>> (SEXT_MAX - w);
  endfunction

endpackage

// File: rtl/force_reduce_timeout.sv
// Idle-cycle counter: clears on demand, counts up to LIMIT and holds there,
// flagging terminal count. LIMIT=0 disables it entirely.
module force_reduce_timeout #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int unsigned CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (LIMIT != 0) && !tc_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tc_o = (LIMIT != 0) && (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/force_reduce_drain.sv
// Drains the reduction FIFO, summing consecutive same-id entries into one
// (id, sum, count) record per run on a valid/ready port toward write-back.
module force_reduce_drain
  import force_reduce_pkg::*;
#(
  parameter int ID_WIDTH      = 16,
  parameter int VAL_WIDTH     = 32,
  parameter int CNT_WIDTH     = 8,
  parameter int FLUSH_TIMEOUT = 16,
  parameter int ENTRY_WIDTH   = 1 + ID_WIDTH + VAL_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ENTRY_WIDTH-1:0]         fifo_out,
  input  logic                           fifo_empty,
  output logic                           fifo_consume,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ID_WIDTH-1:0]            out_id,
  output logic [VAL_WIDTH+CNT_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0]           out_count,
  output logic                           busy
);

  localparam int SUM_W    = VAL_WIDTH + CNT_WIDTH;
  localparam int ID_LSB   = id_lsb(VAL_WIDTH);
  localparam int LAST_BIT = last_bit(ID_WIDTH, VAL_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e               state_q;
  logic [ID_WIDTH-1:0]  cur_id_q;
  logic [SUM_W-1:0]     acc_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic                 head_last;
  logic [ID_WIDTH-1:0]  head_id;
  logic [SUM_W-1:0]     head_val;
  logic [SUM_W-1:0]     acc_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 close_d;
  logic                 to_clr;
  logic                 to_inc;
  logic                 to_tc;

  assign head_last = fifo_out[LAST_BIT];
  assign head_id   = fifo_out[ID_LSB +: ID_WIDTH];
  assign head_val  = SUM_W'(sext(SEXT_MAX'(fifo_out[VAL_WIDTH-1:0]), VAL_WIDTH));

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    fifo_consume = 1'b0;
    case (state_q)
      // Reset parks the FSM in IDLE, so gating this term holds pops off in reset.
      ST_IDLE: fifo_consume = rst && !fifo_empty;
      ST_ACC:  fifo_consume = !fifo_empty && (head_id == cur_id_q);
      default: fifo_consume = 1'b0;
    endcase
  end

  // Running totals as they would stand after popping the current head.
  assign acc_d   = (state_q == ST_IDLE) ? head_val : acc_q + head_val;
  assign cnt_d   = (state_q == ST_IDLE) ? CNT_WIDTH'(1) : cnt_q + CNT_WIDTH'(1);
  assign close_d = head_last || (cnt_d == CNT_MAX);

  assign to_clr = ((state_q == ST_ACC) && fifo_consume) || ((state_q == ST_EMIT) && out_ready);
  assign to_inc = (state_q == ST_ACC) && fifo_empty && !to_tc;
  assign busy   = (state_q != ST_IDLE);

  force_reduce_timeout #(
    .LIMIT(FLUSH_TIMEOUT)
  ) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .clr_i(to_clr),
    .inc_i(to_inc),
    .tc_o (to_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cur_id_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_sum   <= '0;
      out_count <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACC: begin
          if (fifo_consume) begin
            cur_id_q <= head_id;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            if (close_d) begin
              state_q   <= ST_EMIT;
              out_valid <= 1'b1;
              out_id    <= head_id;
              out_sum   <= acc_d;
              out_count <= cnt_d;
            end else begin
              state_q <= ST_ACC;
            end
          end else if ((state_q == ST_ACC) && (!fifo_empty || to_tc)) begin
            // Head belongs to a different id, or the FIFO stayed dry too long.
            state_q   <= ST_EMIT;
            out_valid <= 1'b1;
            out_id    <= cur_id_q;
            out_sum   <= acc_q;
            out_count <= cnt_q;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            state_q   <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_force_reduce_drain.sv
// Self-checking bench for force_reduce_drain: FIFO models, a run-level
// reference model, table vectors and hand-written timing sequences.
module tb_force_reduce_drain;

  typedef struct {
    logic [15:0] id;
    longint      sum;
    int          cnt;
  } rec_t;

  typedef struct {
    logic [15:0] id;
    int          n;
    int          v0;
    int          v1;
    int          v2;
    longint      sum;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: default parameters.
  logic [48:0] fo0;
  logic        fe0, c0, ov0, rdy0, busy0;
  logic [15:0] oid0;
  logic [39:0] osum0;
  logic [7:0]  ocnt0;
  // Instance 1: CNT_WIDTH=2, FLUSH_TIMEOUT=4.
  logic [48:0] fo1;
  logic        fe1, c1, ov1, rdy1, busy1;
  logic [15:0] oid1;
  logic [33:0] osum1;
  logic [1:0]  ocnt1;
  // Instance 2: FLUSH_TIMEOUT=0.
  logic [48:0] fo2;
  logic        fe2, c2, ov2, rdy2, busy2;
  logic [15:0] oid2;
  logic [39:0] osum2;
  logic [7:0]  ocnt2;

  logic [48:0] q0[$];
  logic [48:0] q1[$];
  logic [48:0] q2[$];
  rec_t        exp0[$];
  rec_t        exp1[$];
  rec_t        exp2[$];

  force_reduce_drain u_dut0 (
    .clk(clk), .rst(rst), .fifo_out(fo0), .fifo_empty(fe0), .fifo_consume(c0),
    .out_valid(ov0), .out_ready(rdy0), .out_id(oid0), .out_sum(osum0),
    .out_count(ocnt0), .busy(busy0)
  );

  force_reduce_drain #(.CNT_WIDTH(2), .FLUSH_TIMEOUT(4)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_out(fo1), .fifo_empty(fe1), .fifo_consume(c1),
    .out_valid(ov1), .out_ready(rdy1), .out_id(oid1), .out_sum(osum1),
    .out_count(ocnt1), .busy(busy1)
  );

  force_reduce_drain #(.FLUSH_TIMEOUT(0)) u_dut2 (
    .clk(clk), .rst(rst), .fifo_out(fo2), .fifo_empty(fe2), .fifo_consume(c2),
    .out_valid(ov2), .out_ready(rdy2), .out_id(oid2), .out_sum(osum2),
    .out_count(ocnt2), .busy(busy2)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic refresh();
    fe0 = (q0.size() == 0);
    fo0 = fe0 ? '0 : q0[0];
    fe1 = (q1.size() == 0);
    fo1 = fe1 ? '0 : q1[0];
    fe2 = (q2.size() == 0);
    fo2 = fe2 ? '0 : q2[0];
  endtask

  task automatic push(input int inst, input logic [15:0] id, input int val, input logic last);
    logic [48:0] e;
    e = {last, id, val};
    case (inst)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    refresh();
  endtask

  task automatic score(input int inst, input logic [15:0] id, input longint sum, input int cnt);
    rec_t r;
    int   sz;
    case (inst)
      0:       sz = exp0.size();
      1:       sz = exp1.size();
      default: sz = exp2.size();
    endcase
    if (sz == 0) begin
      check($sformatf("unexpected_rec%0d", inst), 1, 0);
      return;
    end
    case (inst)
      0:       r = exp0.pop_front();
      1:       r = exp1.pop_front();
      default: r = exp2.pop_front();
    endcase
    check($sformatf("rec%0d_id", inst), longint'(id), longint'(r.id));
    check($sformatf("rec%0d_sum", inst), sum, r.sum);
    check($sformatf("rec%0d_count", inst), longint'(cnt), longint'(r.cnt));
  endtask

  // One clock: sample pops and handshakes before the edge, apply pops after it.
  task automatic cycle();
    logic p0, p1, p2;
    #2;
    p0 = c0;
    p1 = c1;
    p2 = c2;
    check("consume_while_empty0", longint'(p0 && fe0), 0);
    check("consume_while_empty1", longint'(p1 && fe1), 0);
    check("consume_while_empty2", longint'(p2 && fe2), 0);
    if (ov0 && rdy0) score(0, oid0, longint'($signed(osum0)), int'(ocnt0));
    if (ov1 && rdy1) score(1, oid1, longint'($signed(osum1)), int'(ocnt1));
    if (ov2 && rdy2) score(2, oid2, longint'($signed(osum2)), int'(ocnt2));
    @(posedge clk);
    #1;
    if (p0 && q0.size() > 0) void'(q0.pop_front());
    if (p1 && q1.size() > 0) void'(q1.pop_front());
    if (p2 && q2.size() > 0) void'(q2.pop_front());
    refresh();
    @(negedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp0.size() + exp1.size() + exp2.size()) != 0 && n < budget) begin
      cycle();
      n++;
    end
    check(name, longint'(exp0.size() + exp1.size() + exp2.size()), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[5];
    logic [15:0] s_id;
    logic [39:0] s_sum;
    logic [7:0]  s_cnt;
    logic        bad;
    logic        seen;
    int          first;
    int          n;
    logic        open;
    logic [15:0] m_id;
    longint      m_sum;
    int          m_cnt;
    logic [15:0] rid;
    int          rv;
    logic        rl;

    tbl[0] = '{16'd5,    3, 10,  20, -3, 64'sd27};
    tbl[1] = '{16'd6,    1, -1,  0,  0,  -64'sd1};
    tbl[2] = '{16'hffff, 3, 32'h7fffffff, 32'h7fffffff, 1, 64'sd4294967295};
    tbl[3] = '{16'd1,    2, int'(32'h80000000), int'(32'h80000000), 0, -64'sd4294967296};
    tbl[4] = '{16'h1234, 2, 0,   0,  0,  64'sd0};

    rdy0 = 1'b1;
    rdy1 = 1'b1;
    rdy2 = 1'b1;
    refresh();
    repeat (2) @(negedge clk);

    // Reset state, and no pop while reset is held even with data waiting.
    check("rst_valid0", longint'(ov0), 0);
    check("rst_id0", longint'(oid0), 0);
    check("rst_sum0", longint'(osum0), 0);
    check("rst_count0", longint'(ocnt0), 0);
    check("rst_busy0", longint'(busy0), 0);
    check("rst_valid1", longint'(ov1), 0);
    check("rst_valid2", longint'(ov2), 0);
    push(0, 16'd4, 6, 1'b1);
    #2;
    check("consume_in_reset", longint'(c0), 0);
    @(negedge clk);
    rst = 1'b1;
    exp0.push_back('{16'd4, 64'sd6, 1});
    drain("reset_release_drain", 20);

    // Table of complete runs with out_ready held high.
    foreach (tbl[i]) begin
      push(0, tbl[i].id, tbl[i].v0, tbl[i].n == 1);
      if (tbl[i].n > 1) push(0, tbl[i].id, tbl[i].v1, tbl[i].n == 2);
      if (tbl[i].n > 2) push(0, tbl[i].id, tbl[i].v2, 1'b1);
      exp0.push_back('{tbl[i].id, tbl[i].sum, tbl[i].n});
      drain($sformatf("tbl%0d_drain", i), 30);
    end

    // Record appears exactly one cycle after the closing pop.
    push(0, 16'd5, 10, 1'b0);
    push(0, 16'd5, 20, 1'b0);
    push(0, 16'd5, -3, 1'b1);
    exp0.push_back('{16'd5, 64'sd27, 3});
    cycle();
    check("lat_pop1_valid", longint'(ov0), 0);
    cycle();
    check("lat_pop2_valid", longint'(ov0), 0);
    cycle();
    check("lat_pop3_valid", longint'(ov0), 1);
    check("lat_fifo_left", longint'(q0.size()), 0);
    drain("lat_drain", 10);

    // Id change closes the run and leaves the new head in the FIFO.
    push(0, 16'd7, 1, 1'b0);
    push(0, 16'd7, 2, 1'b0);
    push(0, 16'd9, 4, 1'b1);
    exp0.push_back('{16'd7, 64'sd3, 2});
    exp0.push_back('{16'd9, 64'sd4, 1});
    repeat (3) cycle();
    check("idchg_valid", longint'(ov0), 1);
    check("idchg_fifo_left", longint'(q0.size()), 1);
    cycle();
    check("idchg_handshake_valid", longint'(ov0), 0);
    check("idchg_not_popped_yet", longint'(q0.size()), 1);
    cycle();
    check("idchg_second_valid", longint'(ov0), 1);
    check("idchg_second_popped", longint'(q0.size()), 0);
    drain("idchg_drain", 10);

    // Backpressure: record held, no pops, until out_ready returns.
    rdy0 = 1'b0;
    push(0, 16'd8, 5, 1'b1);
    push(0, 16'd8, 6, 1'b1);
    exp0.push_back('{16'd8, 64'sd5, 1});
    exp0.push_back('{16'd8, 64'sd6, 1});
    cycle();
    check("bp_valid", longint'(ov0), 1);
    s_id  = oid0;
    s_sum = osum0;
    s_cnt = ocnt0;
    bad   = 1'b0;
    repeat (10) begin
      cycle();
      if (oid0 != s_id || osum0 != s_sum || ocnt0 != s_cnt || !ov0 || c0 || q0.size() != 1)
        bad = 1'b1;
    end
    check("bp_hold", longint'(bad), 0);
    rdy0 = 1'b1;
    cycle();
    check("bp_accept", longint'(ov0), 0);
    drain("bp_drain", 10);

    // Randomized stream against a run-level reference model.
    open  = 1'b0;
    m_id  = '0;
    m_sum = 0;
    m_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      rid = 16'($urandom_range(0, 3));
      rv  = int'($urandom);
      rl  = ($urandom_range(0, 3) == 0);
      push(0, rid, rv, rl);
      if (open && rid != m_id) begin
        exp0.push_back('{m_id, m_sum, m_cnt});
        open = 1'b0;
      end
      if (!open) begin
        open  = 1'b1;
        m_id  = rid;
        m_sum = 0;
        m_cnt = 0;
      end
      m_sum += longint'(rv);
      m_cnt++;
      if (rl || m_cnt == 255) begin
        exp0.push_back('{m_id, m_sum, m_cnt});
        open = 1'b0;
      end
    end
    if (open) exp0.push_back('{m_id, m_sum, m_cnt});
    n = 0;
    while (exp0.size() != 0 && n < 6000) begin
      rdy0 = ($urandom_range(0, 3) != 0);
      cycle();
      n++;
    end
    rdy0 = 1'b1;
    check("random_drain", longint'(exp0.size()), 0);
    check("random_fifo_empty", longint'(q0.size()), 0);

    // Async reset mid-run discards the partial sum.
    push(0, 16'd1, 3, 1'b0);
    push(0, 16'd1, 4, 1'b0);
    push(0, 16'd1, 5, 1'b0);
    cycle();
    cycle();
    check("arst_busy_before", longint'(busy0), 1);
    rst = 1'b0;
    #1;
    check("arst_valid", longint'(ov0), 0);
    check("arst_busy", longint'(busy0), 0);
    check("arst_count", longint'(ocnt0), 0);
    q0.delete();
    refresh();
    @(negedge clk);
    rst = 1'b1;
    push(0, 16'd1, 8, 1'b1);
    exp0.push_back('{16'd1, 64'sd8, 1});
    drain("arst_recover_drain", 20);

    // Count cap with a 2-bit counter: 3 entries, then 2 flushed by timeout.
    repeat (5) push(1, 16'd3, 1, 1'b0);
    exp1.push_back('{16'd3, 64'sd3, 3});
    exp1.push_back('{16'd3, 64'sd2, 2});
    repeat (3) cycle();
    check("cap_valid", longint'(ov1), 1);
    check("cap_count", longint'(ocnt1), 3);
    drain("cap_drain", 40);

    // Negative sum flushed exactly 5 cycles after the last pop.
    push(1, 16'd2, -100, 1'b0);
    push(1, 16'd2, -28, 1'b0);
    exp1.push_back('{16'd2, -64'sd128, 2});
    cycle();
    cycle();
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (ov1 && first == 0) first = k;
    end
    check("timeout_latency", longint'(first), 5);
    drain("timeout_drain", 20);

    // Timeout disabled: the run waits for the next entry.
    push(2, 16'd2, -100, 1'b0);
    push(2, 16'd2, -28, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      cycle();
      if (ov2) seen = 1'b1;
    end
    check("no_flush_when_disabled", longint'(seen), 0);
    check("no_flush_busy", longint'(busy2), 1);
    push(2, 16'd6, 1, 1'b1);
    exp2.push_back('{16'd2, -64'sd128, 2});
    exp2.push_back('{16'd6, 64'sd1, 1});
    drain("no_flush_drain", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
